// File: rtl/sram_data_port_if.sv
// Request/response bundle between the MEM stage and the SRAM data port.
// The pipeline is the master. The port is the slave and answers with readdata and ready.
interface sram_data_port_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;

  modport master (
    output read, write, address, writedata,
    input  readdata, ready
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, ready
  );
endinterface

// File: rtl/sram_data_port.sv
// Data-memory responder: serves each 32-bit word as two 16-bit asynchronous SRAM phases.
// Until the word is done, ready stays low so the pipeline freezes.
module sram_data_port #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int unsigned ACCESS_CYCLES = 32'd2
) (
  input  logic                clk,
  input  logic                rst,
  sram_data_port_if.slave     bus,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [17:0]         SRAM_ADDR,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 32'd1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;

  logic [16:0] word_s;
  logic        last_s;
  logic        drive_s;
  logic [15:0] dq_out_s;

  // Out-of-range addresses simply alias modulo 2^17 words.
  assign word_s = 17'((addr_q - BASE_ADDR) >> 2);
  assign last_s = (cnt_q == LAST_CNT);

  assign bus.ready    = ~(bus.read | bus.write) | (state_q == DONE);
  assign bus.readdata = rdata_q;

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = drive_s ? dq_out_s : 16'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (bus.read | bus.write) begin
          addr_d  = bus.address;
          wdata_d = bus.writedata;
          wr_d    = bus.write;
          cnt_d   = 3'd0;
          state_d = LOW;
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          cnt_d   = 3'd0;
          state_d = HIGH;
          if (!wr_q) begin
            rdata_d[15:0] = SRAM_DQ;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HIGH: begin
        if (last_s) begin
          cnt_d   = 3'd0;
          state_d = DONE;
          if (!wr_q) begin
            rdata_d[31:16] = SRAM_DQ;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins decode from registered state so an async reset releases the bus at once.
  always_comb begin
    SRAM_ADDR = 18'd0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    drive_s   = 1'b0;
    dq_out_s  = 16'd0;
    case (state_q)
      LOW: begin
        SRAM_ADDR = {word_s, 1'b0};
        SRAM_WE_N = ~wr_q;
        SRAM_OE_N = wr_q;
        drive_s   = wr_q;
        dq_out_s  = wdata_q[15:0];
      end
      HIGH: begin
        SRAM_ADDR = {word_s, 1'b1};
        SRAM_WE_N = ~wr_q;
        SRAM_OE_N = wr_q;
        drive_s   = wr_q;
        dq_out_s  = wdata_q[31:16];
      end
      default: begin
        SRAM_ADDR = 18'd0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        drive_s   = 1'b0;
        dq_out_s  = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_data_port.sv
// Directed bench for sram_data_port: default two-cycle phases plus a one-cycle instance,
// each backed by a simple behavioural asynchronous SRAM.
module tb_sram_data_port;
  logic clk;
  logic rst;
  logic probe;

  sram_data_port_if bus ();
  sram_data_port_if bus2 ();

  wire  [15:0] dq, dq2;
  logic [17:0] addr, addr2;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  logic        we2_n, oe2_n, ce2_n, ub2_n, lb2_n;

  logic [15:0] mem  [0:262143];
  logic [15:0] mem2 [0:262143];

  logic [17:0] log_addr [0:15];
  logic [15:0] log_dq   [0:15];
  logic        log_we   [0:15];

  int checks = 0;
  int errors = 0;
  int st;

  sram_data_port dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_DQ(dq), .SRAM_ADDR(addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_data_port #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(32'd1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .SRAM_DQ(dq2), .SRAM_ADDR(addr2), .SRAM_WE_N(we2_n), .SRAM_OE_N(oe2_n),
    .SRAM_CE_N(ce2_n), .SRAM_UB_N(ub2_n), .SRAM_LB_N(lb2_n)
  );

  // The probe pattern lets the bench see whether the DUT is also driving the bus.
  assign dq  = probe ? 16'h5A5A : ((!oe_n && we_n) ? mem[addr] : 16'hzzzz);
  assign dq2 = (!oe2_n && we2_n) ? mem2[addr2] : 16'hzzzz;

  always @(posedge clk) begin
    if (!we_n) mem[addr] <= dq;
    if (!we2_n) mem2[addr2] <= dq2;
  end

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    @(posedge clk); #1;
    bus.read = 1'b0;  bus.write = 1'b0;
    bus2.read = 1'b0; bus2.write = 1'b0;
  endtask

  // Issue one request and log the SRAM pins for every stalled cycle until ready rises.
  task automatic run_req(input bit sel, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, output int stalls);
    bit seen;
    @(posedge clk); #1;
    if (sel) begin
      bus2.read = !wr; bus2.write = wr; bus2.address = a; bus2.writedata = wd;
    end else begin
      bus.read = !wr; bus.write = wr; bus.address = a; bus.writedata = wd;
    end
    stalls = 0;
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      if ((sel ? bus2.ready : bus.ready) == 1'b1) begin
        seen = 1'b1;
      end else begin
        if (stalls < 16) begin
          log_addr[stalls] = sel ? addr2 : addr;
          log_dq[stalls]   = sel ? dq2 : dq;
          log_we[stalls]   = sel ? we2_n : we_n;
        end
        stalls++;
      end
    end
    check_eq("ready_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; probe = 1'b0;
    bus.read = 1'b0;  bus.write = 1'b0;  bus.address = 32'd0;  bus.writedata = 32'd0;
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = 32'd0; bus2.writedata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_readdata", bus.readdata, 32'd0);
    check_eq("rst_we_n", 32'(we_n), 32'd1);
    check_eq("rst_oe_n", 32'(oe_n), 32'd1);
    probe = 1'b1;
    #1 check_eq("rst_dq_released", 32'(dq), 32'h5A5A);
    probe = 1'b0;

    // Word write at BASE_ADDR: low half then high half, two cycles each
    run_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, st);
    check_eq("wr_stalls", 32'(st), 32'd5);
    check_eq("wr_idle_we_n", 32'(log_we[0]), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("wr_addr", 32'(log_addr[i]), (i <= 2) ? 32'd0 : 32'd1);
      check_eq("wr_dq", 32'(log_dq[i]), (i <= 2) ? 32'hBEEF : 32'hDEAD);
      check_eq("wr_we_n", 32'(log_we[i]), 32'd0);
    end
    check_eq("wr_keeps_readdata", bus.readdata, 32'd0);
    set_idle();

    run_req(1'b0, 1'b0, 32'd1024, 32'd0, st);
    check_eq("rd_stalls", 32'(st), 32'd5);
    check_eq("rd_data", bus.readdata, 32'hDEADBEEF);
    for (int i = 1; i <= 4; i++) begin
      check_eq("rd_addr", 32'(log_addr[i]), (i <= 2) ? 32'd0 : 32'd1);
      check_eq("rd_we_n", 32'(log_we[i]), 32'd1);
    end
    set_idle();

    // Back-to-back: the read is presented in the IDLE cycle right after DONE
    run_req(1'b0, 1'b1, 32'd1028, 32'h12345678, st);
    check_eq("b2b_wr_stalls", 32'(st), 32'd5);
    run_req(1'b0, 1'b0, 32'd1028, 32'd0, st);
    check_eq("b2b_rd_stalls", 32'(st), 32'd5);
    check_eq("b2b_rd_addr_lo", 32'(log_addr[1]), 32'd2);
    check_eq("b2b_rd_addr_hi", 32'(log_addr[3]), 32'd3);
    check_eq("b2b_rd_data", bus.readdata, 32'h12345678);
    set_idle();

    // Reset lands in the HIGH phase of a write
    bus.write = 1'b1; bus.address = 32'd1032; bus.writedata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #2;
    check_eq("mid_high_we_n", 32'(we_n), 32'd0);
    check_eq("mid_high_addr", 32'(addr), 32'd5);
    rst = 1'b1;
    #1;
    check_eq("arst_we_n", 32'(we_n), 32'd1);
    check_eq("arst_oe_n", 32'(oe_n), 32'd1);
    check_eq("arst_addr", 32'(addr), 32'd0);
    bus.write = 1'b0;
    #1 check_eq("arst_ready", 32'(bus.ready), 32'd1);
    check_eq("arst_low_half_written", 32'(mem[4]), 32'hF00D);
    @(posedge clk); #1 rst = 1'b0;
    check_eq("arst_readdata", bus.readdata, 32'd0);

    run_req(1'b0, 1'b0, 32'd1024, 32'd0, st);
    check_eq("post_rst_stalls", 32'(st), 32'd5);
    check_eq("post_rst_data", bus.readdata, 32'hDEADBEEF);
    set_idle();

    // Single-cycle phases
    run_req(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, st);
    check_eq("n1_wr_stalls", 32'(st), 32'd3);
    set_idle();
    run_req(1'b1, 1'b0, 32'd1036, 32'd0, st);
    check_eq("n1_rd_stalls", 32'(st), 32'd3);
    check_eq("n1_rd_addr_lo", 32'(log_addr[1]), 32'd6);
    check_eq("n1_rd_addr_hi", 32'(log_addr[2]), 32'd7);
    check_eq("n1_rd_data", bus2.readdata, 32'hA5A55A5A);
    set_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_data_port.md
Name: sram_data_port

Overview:
- Responder side of the pipeline's data-memory interface.
- Accepts the MEM stage's word read/write request (read, write, address, writedata) and returns readdata plus a ready handshake that stalls the pipeline.
- Serves each 32-bit word as two sequential 16-bit accesses to an external asynchronous SRAM.
- Replaces the on-chip data memory behind MEM_Stage; ready feeds the global freeze of all pipeline registers.

Parameters:
- BASE_ADDR, 1024: byte address of data word 0; subtracted before mapping.
- ACCESS_CYCLES, 2: clock cycles each 16-bit SRAM phase is held (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- read  input  1  MEM-stage read request (MEM_R_En).
- write  input  1  MEM-stage write request (MEM_W_En).
- address  input  32  byte address from ALU result.
- writedata  input  32  store data.
- readdata  output  32  loaded word.
- ready  output  1  1 = request complete or no request; 0 = stall pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_WE_N  output  1  write enable, active low.
- SRAM_OE_N  output  1  output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. A cycle counter cnt (3 bits) runs inside LOW and HIGH.
- Word index: word = (address - BASE_ADDR) >> 2, truncated to 17 bits. SRAM_ADDR = {word, half}. half = 0 in LOW, 1 in HIGH.
- IDLE:
  - If (read | write), latch address, writedata and op (write has priority if both are asserted; both asserted is illegal upstream).
  - Then go to LOW with cnt = 0.
- LOW / HIGH:
  - Hold for ACCESS_CYCLES cycles. cnt increments each cycle.
  - On cnt == ACCESS_CYCLES-1, advance LOW->HIGH or HIGH->DONE and clear cnt.
- DONE: unconditionally go to IDLE next cycle.
- ready = ~(read | write) | (state == DONE). This is combinational. The pipeline holds request inputs stable while ready = 0.
- Latency with ACCESS_CYCLES = N: request first seen in cycle t gives ready = 0 for cycles t..t+2N and ready = 1 in cycle t+2N+1 (DONE). Default N = 2 gives 5 stall cycles.
- Back-to-back requests: a new request visible in the cycle after DONE is accepted from IDLE. There is no idle gap beyond that one IDLE cycle.
- Write phases:
  - SRAM_WE_N = 0 and SRAM_OE_N = 1.
  - SRAM_DQ is driven with writedata[15:0] in LOW and writedata[31:16] in HIGH.
- Read phases:
  - SRAM_WE_N = 1, SRAM_OE_N = 0, SRAM_DQ = Z.
  - On the last cycle of LOW, capture SRAM_DQ into readdata[15:0]. On the last cycle of HIGH, capture into readdata[31:16].
  - readdata is valid in DONE and is held until the next read completes. Writes never change readdata.
- IDLE / DONE: SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ = Z, SRAM_ADDR = 0.
- Reset values:
  - state IDLE, cnt 0, readdata 0, latched registers 0.
  - Outputs: SRAM_WE_N 1, SRAM_OE_N 1, SRAM_DQ Z.
  - ready follows its equation (1 when no request).
- Reset mid-operation: the access is abandoned immediately (asynchronous). SRAM_WE_N returns to 1 and the bus is released in the same instant. No partial readdata update occurs.
- Request dropped while ready = 0 is a protocol violation. The FSM completes the latched access anyway.
- Address wrap: out-of-range addresses alias modulo 2^17 words, with no error.

Test Plan:
- After reset with read = write = 0 -> ready = 1, readdata = 0, SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ = Z.
- write = 1, address = 1024, writedata = 0xDEADBEEF, N = 2 -> both halves are written (see the per-phase checks below).
  - SRAM_ADDR = 0 with DQ = 0xBEEF for 2 cycles, then SRAM_ADDR = 1 with DQ = 0xDEAD for 2 cycles.
  - SRAM_WE_N = 0 throughout those 4 cycles.
  - ready = 0 for 5 cycles, then 1 for one cycle.
- read = 1, address = 1024 against an SRAM model holding that data -> ready = 1 on the 6th cycle and readdata = 0xDEADBEEF; SRAM_ADDR sequence 0, 0, 1, 1.
- Back-to-back: write to 1028 (data 0x12345678), then read from 1028 on the cycle after DONE -> second access starts immediately with SRAM_ADDR = 2, then 3. Read returns 0x12345678.
- Assert rst during the HIGH phase of a write -> SRAM_WE_N = 1 asynchronously, state IDLE. The next read of an unrelated address completes normally.
- ACCESS_CYCLES = 1 -> read latency is 3 stall cycles plus 1 ready cycle; readdata is correct.
